// File: rtl/ctr_pkg.sv
// Shared types and constants for the counter-steal arbiter and its
// ones'-complement increment/decrement helper.
package ctr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    MODIFY = 2'd2,
    WRITE  = 2'd3
  } state_t;

  localparam int WORD_W = 15;

  // 15-bit ones'-complement landmarks
  localparam logic [WORD_W-1:0] POS_MAX  = 15'o37777;
  localparam logic [WORD_W-1:0] NEG_MAX  = 15'o40000;
  localparam logic [WORD_W-1:0] NEG_ZERO = 15'o77777;
  localparam logic [WORD_W-1:0] NEG_ONE  = 15'o77776;

  localparam logic [11:0] CTR_BASE_DEFAULT = 12'o24;

  localparam logic DIR_PINC = 1'b1;
  localparam logic DIR_MINC = 1'b0;

endpackage

// File: rtl/ones_comp_incdec.sv
// Combinational 15-bit ones'-complement +1 / -1 with overflow flag.
// +0 and -0 are both treated as zero: -0 increments to +1 and +0
// decrements to -1, so neither step lands on the other zero.
module ones_comp_incdec
  import ctr_pkg::*;
(
  input  logic [WORD_W-1:0] v,
  input  logic              dir,
  output logic [WORD_W-1:0] result,
  output logic              ovf
);

  // Select the special-case or plain modular result
  always_comb begin
    result = v;
    ovf    = 1'b0;
    if (dir == DIR_PINC) begin
      if (v == POS_MAX) begin
        result = '0;
        ovf    = 1'b1;
      end else if (v == NEG_ZERO) begin
        result = 15'd1;
      end else begin
        result = v + 15'd1;
      end
    end else begin
      if (v == NEG_MAX) begin
        result = NEG_ZERO;
        ovf    = 1'b1;
      end else if (v == '0) begin
        result = NEG_ONE;
      end else begin
        result = v - 15'd1;
      end
    end
  end

endmodule

// File: rtl/counter_steal_arbiter.sv
// Steals memory cycles from the instruction sequencer to apply pending
// PINC/MINC requests to the counter cells with a read-modify-write.
//
// state  | meaning
// IDLE   | no steal in progress; grants when boundary & a request pends
// READ   | mem_rd of the selected counter word
// MODIFY | read data arrives; new value and overflow are registered
// WRITE  | mem_wr of the new value, ovf_pulse if it overflowed
module counter_steal_arbiter
  import ctr_pkg::*;
#(
  parameter int             NCTR     = 4,
  parameter int             AW       = 12,
  parameter logic [AW-1:0]  CTR_BASE = AW'(CTR_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCTR-1:0]   pinc_req,
  input  logic [NCTR-1:0]   minc_req,
  input  logic              boundary,
  output logic              cpu_hold,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [NCTR-1:0]   ovf_pulse,
  output logic              busy
);

  localparam int IDX_W = (NCTR > 1) ? $clog2(NCTR) : 1;

  state_t            state, state_nxt;
  logic [NCTR-1:0]   pinc_pend, minc_pend;
  logic [NCTR-1:0]   cancel, eff_p, eff_m, pend_any;
  logic [NCTR-1:0]   clr_p, clr_m;
  logic              any_pend, grant;
  logic [IDX_W-1:0]  sel_idx, idx_q;
  logic              sel_dir, dir_q;
  logic [WORD_W-1:0] val_q, calc_val;
  logic              ovf_q, calc_ovf;
  logic [AW-1:0]     ctr_addr;

  // An increment and a decrement on the same cell annihilate
  assign cancel   = pinc_pend & minc_pend;
  assign eff_p    = pinc_pend & ~cancel;
  assign eff_m    = minc_pend & ~cancel;
  assign pend_any = eff_p | eff_m;
  assign any_pend = |pend_any;
  assign grant    = (state == IDLE) & boundary & any_pend;
  assign ctr_addr = CTR_BASE + AW'(idx_q);

  // Lowest-index pending counter wins; PINC takes its direction
  always_comb begin
    sel_idx = '0;
    sel_dir = DIR_MINC;
    for (int i = NCTR - 1; i >= 0; i--) begin
      if (pend_any[i]) begin
        sel_idx = IDX_W'(i);
        sel_dir = eff_p[i];
      end
    end
  end

  // Clear mask for the bit consumed by this cycle's grant
  always_comb begin
    clr_p = '0;
    clr_m = '0;
    if (grant) begin
      if (sel_dir == DIR_PINC) clr_p[sel_idx] = 1'b1;
      else                     clr_m[sel_idx] = 1'b1;
    end
  end

  // Pending latches; a new request in the clearing cycle survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pinc_pend <= '0;
      minc_pend <= '0;
    end else begin
      pinc_pend <= (eff_p & ~clr_p) | pinc_req;
      minc_pend <= (eff_m & ~clr_m) | minc_req;
    end
  end

  ones_comp_incdec u_incdec (
    .v      (mem_rdata),
    .dir    (dir_q),
    .result (calc_val),
    .ovf    (calc_ovf)
  );

  // Steal context: target counter, direction and computed word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      dir_q <= DIR_MINC;
      val_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (grant) begin
        idx_q <= sel_idx;
        dir_q <= sel_dir;
      end
      if (state == MODIFY) begin
        val_q <= calc_val;
        ovf_q <= calc_ovf;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; WRITE always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = READ;
      READ:    state_nxt = MODIFY;
      MODIFY:  state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; cpu_hold is combinational so the grant cycle is frozen too
  always_comb begin
    busy      = (state != IDLE);
    cpu_hold  = (state != IDLE) | grant;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ovf_pulse = '0;
    case (state)
      READ: begin
        mem_rd   = 1'b1;
        mem_addr = ctr_addr;
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = ctr_addr;
        mem_wdata = val_q;
        if (ovf_q) ovf_pulse = NCTR'(1) << idx_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_steal_arbiter.sv
// Directed bench for counter_steal_arbiter with a simple memory model.
module tb_counter_steal_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  pinc_req;
  logic [3:0]  minc_req;
  logic        boundary;
  logic        cpu_hold;
  logic        mem_rd;
  logic        mem_wr;
  logic [11:0] mem_addr;
  logic [14:0] mem_wdata;
  logic [14:0] mem_rdata;
  logic [3:0]  ovf_pulse;
  logic        busy;

  logic        ld_en;
  logic [11:0] ld_addr;
  logic [14:0] ld_data;
  logic [14:0] mem [0:4095];

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int hold_cnt = 0;
  int ovf_cnt = 0;

  counter_steal_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pinc_req  (pinc_req),
    .minc_req  (minc_req),
    .boundary  (boundary),
    .cpu_hold  (cpu_hold),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .ovf_pulse (ovf_pulse),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one-cycle read latency, plus a bench-side preload port
  always @(posedge clk) begin
    if (ld_en)  mem[ld_addr] <= ld_data;
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Activity counters sampled on each active edge
  always @(posedge clk) begin
    if (mem_rd)     rd_cnt   <= rd_cnt + 1;
    if (mem_wr)     wr_cnt   <= wr_cnt + 1;
    if (cpu_hold)   hold_cnt <= hold_cnt + 1;
    if (|ovf_pulse) ovf_cnt  <= ovf_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [11:0] a, input logic [14:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  // Called in the grant cycle; walks READ/MODIFY/WRITE and the IDLE after it
  task automatic steal_check(input string tag, input logic [11:0] addr,
                             input logic [14:0] wdata, input logic [3:0] ovf,
                             input logic nb);
    int h0, o0;
    chk({tag, " grant hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, " grant busy"}, 32'(busy), 32'd0);
    chk({tag, " grant rd"}, 32'(mem_rd), 32'd0);
    h0 = hold_cnt;
    o0 = ovf_cnt;
    tick();
    chk({tag, " read rd"}, 32'(mem_rd), 32'd1);
    chk({tag, " read addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, " read busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, " modify rd"}, 32'(mem_rd), 32'd0);
    chk({tag, " modify wr"}, 32'(mem_wr), 32'd0);
    chk({tag, " modify hold"}, 32'(cpu_hold), 32'd1);
    tick();
    chk({tag, " write wr"}, 32'(mem_wr), 32'd1);
    chk({tag, " write addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, " write data"}, 32'(mem_wdata), 32'(wdata));
    chk({tag, " write ovf"}, 32'(ovf_pulse), 32'(ovf));
    boundary = nb;
    tick();
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " hold cycles"}, 32'(hold_cnt - h0), 32'd4);
    chk({tag, " ovf cycles"}, 32'(ovf_cnt - o0), (ovf != 4'd0) ? 32'd1 : 32'd0);
    chk({tag, " mem word"}, 32'(mem[addr]), 32'(wdata));
  endtask

  initial begin
    int r0, w0, h0;
    rst_n    = 1'b0;
    pinc_req = '0;
    minc_req = '0;
    boundary = 1'b0;
    ld_en    = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    tick();
    tick();
    chk("rst hold", 32'(cpu_hold), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rd", 32'(mem_rd), 32'd0);
    chk("rst wr", 32'(mem_wr), 32'd0);
    chk("rst addr", 32'(mem_addr), 32'd0);
    chk("rst wdata", 32'(mem_wdata), 32'd0);
    chk("rst ovf", 32'(ovf_pulse), 32'd0);
    rst_n = 1'b1;
    tick();

    // Plain increment 5 -> 6 on counter 0
    load(12'o24, 15'o00005);
    boundary = 1'b1;
    pinc_req = 4'b0001;
    #1;
    chk("t1 hold before latch", 32'(cpu_hold), 32'd0);
    tick();
    pinc_req = '0;
    steal_check("t1", 12'o24, 15'o00006, 4'b0000, 1'b1);
    chk("t1 hold after", 32'(cpu_hold), 32'd0);

    // +max increments to +0 with overflow on counter 1
    load(12'o25, 15'o37777);
    pinc_req = 4'b0010;
    tick();
    pinc_req = '0;
    steal_check("t2 pinc max", 12'o25, 15'o00000, 4'b0010, 1'b1);

    // +0 decrements to -1 on counter 3
    load(12'o27, 15'o00000);
    minc_req = 4'b1000;
    tick();
    minc_req = '0;
    steal_check("t2 minc zero", 12'o27, 15'o77776, 4'b0000, 1'b1);

    // -max decrements to -0 with overflow on counter 0
    load(12'o24, 15'o40000);
    minc_req = 4'b0001;
    tick();
    minc_req = '0;
    steal_check("t2 minc max", 12'o24, 15'o77777, 4'b0001, 1'b1);

    // -0 increments to +1 on counter 0
    pinc_req = 4'b0001;
    tick();
    pinc_req = '0;
    steal_check("t2 pinc negzero", 12'o24, 15'o00001, 4'b0000, 1'b1);

    // Simultaneous requests: counter 0 first, gap, then counter 2
    load(12'o26, 15'o00100);
    pinc_req = 4'b0101;
    tick();
    pinc_req = '0;
    steal_check("t3 c0", 12'o24, 15'o00002, 4'b0000, 1'b0);
    chk("t3 gap hold", 32'(cpu_hold), 32'd0);
    boundary = 1'b1;
    #1;
    steal_check("t3 c2", 12'o26, 15'o00101, 4'b0000, 1'b1);

    // PINC then MINC on counter 3 cancel while boundary is low
    boundary = 1'b0;
    pinc_req = 4'b1000;
    tick();
    pinc_req = '0;
    minc_req = 4'b1000;
    tick();
    minc_req = '0;
    tick();
    r0 = rd_cnt;
    w0 = wr_cnt;
    boundary = 1'b1;
    #1;
    chk("t4 hold", 32'(cpu_hold), 32'd0);
    tick();
    tick();
    tick();
    chk("t4 rd count", 32'(rd_cnt - r0), 32'd0);
    chk("t4 wr count", 32'(wr_cnt - w0), 32'd0);
    chk("t4 busy", 32'(busy), 32'd0);
    chk("t4 mem word", 32'(mem[12'o27]), 32'o77776);

    // Request waits through 20 cycles of no boundary
    boundary = 1'b0;
    pinc_req = 4'b0010;
    tick();
    pinc_req = '0;
    r0 = rd_cnt;
    h0 = hold_cnt;
    for (int k = 0; k < 20; k++) tick();
    chk("t5 hold count", 32'(hold_cnt - h0), 32'd0);
    chk("t5 rd count", 32'(rd_cnt - r0), 32'd0);
    chk("t5 hold now", 32'(cpu_hold), 32'd0);
    boundary = 1'b1;
    #1;
    steal_check("t5", 12'o25, 15'o00001, 4'b0000, 1'b1);

    // Reset during MODIFY abandons the steal and drops pending work
    pinc_req = 4'b0100;
    tick();
    pinc_req = '0;
    chk("t6 grant hold", 32'(cpu_hold), 32'd1);
    tick();
    pinc_req = 4'b0010;
    chk("t6 read rd", 32'(mem_rd), 32'd1);
    tick();
    pinc_req = '0;
    chk("t6 modify busy", 32'(busy), 32'd1);
    w0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("t6 rst hold", 32'(cpu_hold), 32'd0);
    chk("t6 rst busy", 32'(busy), 32'd0);
    chk("t6 rst rd", 32'(mem_rd), 32'd0);
    chk("t6 rst wr", 32'(mem_wr), 32'd0);
    chk("t6 rst addr", 32'(mem_addr), 32'd0);
    chk("t6 rst wdata", 32'(mem_wdata), 32'd0);
    chk("t6 rst ovf", 32'(ovf_pulse), 32'd0);
    h0 = hold_cnt;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("t6 wr count", 32'(wr_cnt - w0), 32'd0);
    chk("t6 hold count", 32'(hold_cnt - h0), 32'd0);
    chk("t6 hold now", 32'(cpu_hold), 32'd0);
    chk("t6 mem word c2", 32'(mem[12'o26]), 32'o00101);
    chk("t6 mem word c1", 32'(mem[12'o25]), 32'o00001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
